posit_check_sequencer: RTL and testbench
========================================

# posit_check_sequencer

Sequential controller that wraps the combinational posit fault-checking adder datapath (full-width reference adder, truncated adder, punt adder, scale-compare fault flag). It accepts operand pairs over a valid/ready handshake and holds them stable on the checker inputs for a programmable settle window. It then samples the checker outputs, selects the delivered sum and presents the result over a second valid/ready handshake, while keeping saturating usage and fault statistics.

## Interface
- FULL_NBITS, 32, full posit width
- TRUNC_NBITS, 16, truncated posit width
- SETTLE_CYCLES, 2, cycles operands are held on the checker before sampling; legal range 1..15
- CNT_W, 16, width of each statistics counter
- clk  in  1  clock, all state rising-edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer can accept a pair
- in_a, in_b  in  FULL_NBITS  operand posits
- chk_a, chk_b  out  FULL_NBITS  registered operands driven to the checker
- chk_fault  in  1  checker fault flag (scale mismatch > 1)
- chk_mode  in  1  checker mode, 1 = truncated adder used, 0 = punt adder used
- chk_true_sum  in  FULL_NBITS  checker full-width sum
- chk_used_sum  in  FULL_NBITS  checker sum; truncated result sits in bits [TRUNC_NBITS-1:0] when chk_mode=1
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  FULL_NBITS  delivered sum
- out_fault  out  1  fault observed for this pair
- out_trunc  out  1  chk_mode sampled for this pair
- clear_stats  in  1  synchronous clear of all counters
- trunc_cnt, punt_cnt, fault_cnt  out  CNT_W  saturating event counters

## Operation
- FSM states: IDLE, SETTLE, EVAL, HOLD.
- IDLE: in_ready=1. When in_valid=1, register in_a/in_b into chk_a/chk_b, load the settle counter with SETTLE_CYCLES-1 and go to SETTLE.
- SETTLE: in_ready=0. chk_a/chk_b are frozen. Decrement the counter each cycle and go to EVAL on the cycle the counter is 0.
- EVAL (one cycle): sample chk_*.
  - out_fault<=chk_fault, out_trunc<=chk_mode.
  - Sum select: if chk_mode=1, the candidate sum is {chk_used_sum[TRUNC_NBITS-1:0], (FULL_NBITS-TRUNC_NBITS) zeros}; otherwise the candidate is chk_used_sum.
  - out_sum<=candidate, except when the retry feature is enabled and chk_fault=1 (see Configuration).
  - Increment trunc_cnt if chk_mode=1, otherwise punt_cnt. Increment fault_cnt if chk_fault=1.
  - Go to HOLD with out_valid<=1.
- HOLD: out_sum, out_fault and out_trunc are stable. When out_ready=1, out_valid<=0 and go to IDLE. A new pair is accepted no earlier than the following cycle; there is no bypass.
- Counters saturate at all-ones and never wrap.
- clear_stats=1 zeroes all counters. If clear_stats coincides with an EVAL increment, clear wins and the result is 0.
- chk_a/chk_b keep their last value in IDLE; they are not cleared after a transaction.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_fault=0, out_trunc=0, chk_a=chk_b=0, all counters 0.
- Accept handshake on cycle 0. Cycles 1..SETTLE_CYCLES are SETTLE. EVAL is cycle SETTLE_CYCLES+1. out_valid=1 from cycle SETTLE_CYCLES+2.
- Minimum issue interval: SETTLE_CYCLES+3 cycles when out_ready is held at 1.
- out_ready=1 while out_valid=0 is ignored.
- in_valid during SETTLE, EVAL or HOLD is not accepted; the upstream block holds its data.
- An rst_n assertion mid-transaction aborts immediately to the reset values; the in-flight pair is dropped and no counter is updated.

## Configuration
- PCS_FAULT_RETRY_EN defined: when chk_fault=1 in EVAL, out_sum<=chk_true_sum (full-precision recovery). out_fault is still reported as 1.
- PCS_FAULT_RETRY_EN undefined: out_sum is always the candidate sum. out_fault is reported only.

## Test plan
- Reset release, then in_a=in_b=0x40000000 with checker model chk_mode=1, chk_used_sum=0x00004800, chk_fault=0, SETTLE_CYCLES=2 -> out_valid at cycle 4, out_sum=0x48000000, out_trunc=1, trunc_cnt=1.
- chk_mode=0, chk_used_sum=0x12345678, chk_fault=0 -> out_sum=0x12345678, out_trunc=0, punt_cnt=1.
- chk_fault=1, chk_true_sum=0x4A000000, chk_mode=1, chk_used_sum=0x00004800 -> with the macro out_sum=0x4A000000; without it out_sum=0x48000000. out_fault=1 and fault_cnt=1 in both builds.
- Hold out_ready=0 for 5 cycles while pulsing in_valid -> out_valid and out_sum stable, in_ready=0 throughout, no second accept. out_ready=1 -> IDLE next cycle.
- Preload fault_cnt to all-ones (via 2^CNT_W faults with CNT_W=4) -> stays at 0xF. Assert clear_stats during an EVAL with fault -> fault_cnt=0.
- Assert rst_n=0 during SETTLE -> out_valid stays 0, counters unchanged at 0, in_ready=1 after release.

Source files
------------

// File: rtl/posit_check_sequencer_if.sv
// Operand-in and result-out valid/ready channels of posit_check_sequencer.
// The master drives operands and out_ready; the slave (sequencer) drives results.
interface posit_check_sequencer_if #(
    parameter int unsigned FULL_NBITS = 32
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [FULL_NBITS-1:0] in_a;
    logic [FULL_NBITS-1:0] in_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [FULL_NBITS-1:0] out_sum;
    logic                  out_fault;
    logic                  out_trunc;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_fault, out_trunc
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_fault, out_trunc
    );
endinterface

// File: rtl/posit_check_sequencer.sv
// Holds an operand pair on the posit fault-checking adder for a settle window, then
// samples it and returns the selected sum with usage/fault statistics. Option: PCS_FAULT_RETRY_EN.
module posit_check_sequencer #(
    parameter int unsigned FULL_NBITS    = 32,
    parameter int unsigned TRUNC_NBITS   = 16,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    posit_check_sequencer_if.slave bus,
    output logic [FULL_NBITS-1:0]  chk_a_o,
    output logic [FULL_NBITS-1:0]  chk_b_o,
    input  logic                   chk_fault_i,
    input  logic                   chk_mode_i,
    input  logic [FULL_NBITS-1:0]  chk_true_sum_i,
    input  logic [FULL_NBITS-1:0]  chk_used_sum_i,
    input  logic                   clear_stats_i,
    output logic [CNT_W-1:0]       trunc_cnt_o,
    output logic [CNT_W-1:0]       punt_cnt_o,
    output logic [CNT_W-1:0]       fault_cnt_o
);
    localparam int unsigned PAD_W    = FULL_NBITS - TRUNC_NBITS;
    localparam int unsigned SETTLE_W = 4;
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, EVAL, HOLD} state_e;

    state_e                state_q, state_d;
    logic [SETTLE_W-1:0]   settle_q, settle_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [FULL_NBITS-1:0] out_sum_q, out_sum_d;
    logic                  out_fault_q, out_fault_d;
    logic                  out_trunc_q, out_trunc_d;
    logic [FULL_NBITS-1:0] chk_a_q, chk_a_d;
    logic [FULL_NBITS-1:0] chk_b_q, chk_b_d;
    logic [CNT_W-1:0]      trunc_cnt_q, trunc_cnt_d;
    logic [CNT_W-1:0]      punt_cnt_q, punt_cnt_d;
    logic [CNT_W-1:0]      fault_cnt_q, fault_cnt_d;
    logic [FULL_NBITS-1:0] cand_sum;
    logic [FULL_NBITS-1:0] eval_sum;

    // Truncated result is left-aligned into the full-width posit field
    assign cand_sum = chk_mode_i ? {chk_used_sum_i[TRUNC_NBITS-1:0], PAD_W'(0)}
                                 : chk_used_sum_i;

`ifdef PCS_FAULT_RETRY_EN
    assign eval_sum = chk_fault_i ? chk_true_sum_i : cand_sum;
`else
    assign eval_sum = cand_sum;
    // Full-precision sum is only consumed when fault recovery is built in
    logic unused_true_sum;
    assign unused_true_sum = ^chk_true_sum_i;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_fault_d = out_fault_q;
        out_trunc_d = out_trunc_q;
        chk_a_d     = chk_a_q;
        chk_b_d     = chk_b_q;
        trunc_cnt_d = trunc_cnt_q;
        punt_cnt_d  = punt_cnt_q;
        fault_cnt_d = fault_cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    chk_a_d  = bus.in_a;
                    chk_b_d  = bus.in_b;
                    settle_d = SETTLE_LOAD;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_q == '0) begin
                    state_d = EVAL;
                end else begin
                    settle_d = settle_q - SETTLE_W'(1);
                end
            end
            EVAL: begin
                out_sum_d   = eval_sum;
                out_fault_d = chk_fault_i;
                out_trunc_d = chk_mode_i;
                if (chk_mode_i) begin
                    trunc_cnt_d = sat_inc(trunc_cnt_q);
                end else begin
                    punt_cnt_d = sat_inc(punt_cnt_q);
                end
                if (chk_fault_i) begin
                    fault_cnt_d = sat_inc(fault_cnt_q);
                end
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear takes priority over a same-cycle increment
        if (clear_stats_i) begin
            trunc_cnt_d = '0;
            punt_cnt_d  = '0;
            fault_cnt_d = '0;
        end

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            settle_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_fault_q <= 1'b0;
            out_trunc_q <= 1'b0;
            chk_a_q     <= '0;
            chk_b_q     <= '0;
            trunc_cnt_q <= '0;
            punt_cnt_q  <= '0;
            fault_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_fault_q <= out_fault_d;
            out_trunc_q <= out_trunc_d;
            chk_a_q     <= chk_a_d;
            chk_b_q     <= chk_b_d;
            trunc_cnt_q <= trunc_cnt_d;
            punt_cnt_q  <= punt_cnt_d;
            fault_cnt_q <= fault_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_fault = out_fault_q;
    assign bus.out_trunc = out_trunc_q;
    assign chk_a_o       = chk_a_q;
    assign chk_b_o       = chk_b_q;
    assign trunc_cnt_o   = trunc_cnt_q;
    assign punt_cnt_o    = punt_cnt_q;
    assign fault_cnt_o   = fault_cnt_q;

endmodule

// File: tb/tb_posit_check_sequencer.sv
// Bench for posit_check_sequencer: timestamp-based reference model compared every cycle,
// plus directed transactions with hand-computed literal expectations.
module tb_posit_check_sequencer;
    localparam int unsigned FULL   = 32;
    localparam int unsigned TRUNC  = 16;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned CW     = 4;
    localparam int          MAXC   = (1 << CW) - 1;

    logic             clk;
    logic             rst_n;
    logic             chk_fault;
    logic             chk_mode;
    logic [FULL-1:0]  chk_true_sum;
    logic [FULL-1:0]  chk_used_sum;
    logic [FULL-1:0]  chk_a;
    logic [FULL-1:0]  chk_b;
    logic             clear_stats;
    logic [CW-1:0]    trunc_cnt;
    logic [CW-1:0]    punt_cnt;
    logic [CW-1:0]    fault_cnt;

    posit_check_sequencer_if #(.FULL_NBITS(FULL)) ifc ();

    posit_check_sequencer #(
        .FULL_NBITS(FULL), .TRUNC_NBITS(TRUNC), .SETTLE_CYCLES(SETTLE), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifc),
        .chk_a_o(chk_a), .chk_b_o(chk_b),
        .chk_fault_i(chk_fault), .chk_mode_i(chk_mode),
        .chk_true_sum_i(chk_true_sum), .chk_used_sum_i(chk_used_sum),
        .clear_stats_i(clear_stats),
        .trunc_cnt_o(trunc_cnt), .punt_cnt_o(punt_cnt), .fault_cnt_o(fault_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit run   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_sum(input logic mode, input logic fault,
                                             input logic [31:0] used, input logic [31:0] tru);
`ifdef PCS_FAULT_RETRY_EN
        if (fault) return tru;
`else
        if (fault && tru === 32'hx) return 32'h0;
`endif
        if (mode) return used << (FULL - TRUNC);
        return used;
    endfunction

    // Reference model: events keyed on a cycle count rather than on FSM states
    bit          m_in_ready, m_valid, m_fault, m_trunc, m_pending;
    logic [31:0] m_sum, m_a, m_b;
    int          m_tc, m_pc, m_fc, m_cyc, m_eval_cyc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_in_ready = 1'b1; m_valid = 1'b0; m_fault = 1'b0; m_trunc = 1'b0;
            m_pending = 1'b0; m_sum = '0; m_a = '0; m_b = '0;
            m_tc = 0; m_pc = 0; m_fc = 0; m_cyc = 0; m_eval_cyc = 0;
        end else begin
            m_cyc++;
            if (m_valid && ifc.out_ready) begin
                m_valid    = 1'b0;
                m_in_ready = 1'b1;
            end else if (m_pending && m_cyc == m_eval_cyc) begin
                m_pending = 1'b0;
                m_valid   = 1'b1;
                m_sum     = exp_sum(chk_mode, chk_fault, chk_used_sum, chk_true_sum);
                m_fault   = chk_fault;
                m_trunc   = chk_mode;
                if (chk_mode) m_tc = (m_tc < MAXC) ? m_tc + 1 : MAXC;
                else          m_pc = (m_pc < MAXC) ? m_pc + 1 : MAXC;
                if (chk_fault) m_fc = (m_fc < MAXC) ? m_fc + 1 : MAXC;
            end else if (m_in_ready && ifc.in_valid) begin
                m_a        = ifc.in_a;
                m_b        = ifc.in_b;
                m_in_ready = 1'b0;
                m_pending  = 1'b1;
                m_eval_cyc = m_cyc + SETTLE + 1;
            end
            if (clear_stats) begin
                m_tc = 0; m_pc = 0; m_fc = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            check("m_in_ready",  32'(ifc.in_ready),  32'(m_in_ready));
            check("m_out_valid", 32'(ifc.out_valid), 32'(m_valid));
            check("m_out_sum",   ifc.out_sum,        m_sum);
            check("m_out_fault", 32'(ifc.out_fault), 32'(m_fault));
            check("m_out_trunc", 32'(ifc.out_trunc), 32'(m_trunc));
            check("m_chk_a",     chk_a,              m_a);
            check("m_chk_b",     chk_b,              m_b);
            check("m_trunc_cnt", 32'(trunc_cnt),     32'(m_tc));
            check("m_punt_cnt",  32'(punt_cnt),      32'(m_pc));
            check("m_fault_cnt", 32'(fault_cnt),     32'(m_fc));
        end
    end

    // One pair through the sequencer; lat = negedges from issue until out_valid (0 = timeout)
    task automatic txn(input logic [31:0] a, input logic [31:0] b, input logic mode,
                       input logic fault, input logic [31:0] used, input logic [31:0] tru,
                       input bit clr_eval, output int lat);
        @(negedge clk);
        ifc.in_valid = 1'b1; ifc.in_a = a; ifc.in_b = b;
        chk_mode = mode; chk_fault = fault; chk_used_sum = used; chk_true_sum = tru;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) ifc.in_valid = 1'b0;
            clear_stats = clr_eval && (i == SETTLE + 1);
            if (ifc.out_valid) begin
                lat = i;
                break;
            end
        end
        clear_stats   = 1'b0;
        ifc.out_ready = 1'b1;
        @(negedge clk);
        ifc.out_ready = 1'b0;
    endtask

    int lat;
    int vcount;

    initial begin
        rst_n = 1'b0;
        ifc.in_valid = 1'b0; ifc.in_a = '0; ifc.in_b = '0; ifc.out_ready = 1'b0;
        chk_fault = 1'b0; chk_mode = 1'b0; chk_true_sum = '0; chk_used_sum = '0;
        clear_stats = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        run = 1'b1;
        @(negedge clk);
        check("rst_in_ready",  32'(ifc.in_ready),  32'd1);
        check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        check("rst_out_sum",   ifc.out_sum,        32'h0);
        check("rst_chk_a",     chk_a,              32'h0);
        check("rst_fault_cnt", 32'(fault_cnt),     32'd0);

        txn(32'h40000000, 32'h40000000, 1'b1, 1'b0, 32'h00004800, 32'h48000000, 1'b0, lat);
        check("t1_latency",   32'(lat),           32'd4);
        check("t1_out_sum",   ifc.out_sum,        32'h48000000);
        check("t1_out_trunc", 32'(ifc.out_trunc), 32'd1);
        check("t1_trunc_cnt", 32'(trunc_cnt),     32'd1);

        txn(32'h3C000000, 32'h38000000, 1'b0, 1'b0, 32'h12345678, 32'h12345678, 1'b0, lat);
        check("t2_out_sum",   ifc.out_sum,        32'h12345678);
        check("t2_out_trunc", 32'(ifc.out_trunc), 32'd0);
        check("t2_punt_cnt",  32'(punt_cnt),      32'd1);

        txn(32'h50000000, 32'h70000000, 1'b1, 1'b1, 32'h00004800, 32'h4A000000, 1'b0, lat);
`ifdef PCS_FAULT_RETRY_EN
        check("t3_out_sum", ifc.out_sum, 32'h4A000000);
`else
        check("t3_out_sum", ifc.out_sum, 32'h48000000);
`endif
        check("t3_out_fault", 32'(ifc.out_fault), 32'd1);
        check("t3_fault_cnt", 32'(fault_cnt),     32'd1);

        // Backpressure with in_valid pulsing while the result is held
        @(negedge clk);
        ifc.in_valid = 1'b1; ifc.in_a = 32'h11111111; ifc.in_b = 32'h22222222;
        chk_mode = 1'b0; chk_fault = 1'b0; chk_used_sum = 32'hCAFEF00D;
        @(negedge clk);
        ifc.in_valid = 1'b0;
        for (int i = 0; i < 20 && !ifc.out_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            ifc.in_valid = (i % 2 == 0);
            ifc.in_a = 32'hDEAD0000 + 32'(i);
            @(negedge clk);
            check("bp_in_ready",  32'(ifc.in_ready),  32'd0);
            check("bp_out_valid", 32'(ifc.out_valid), 32'd1);
            check("bp_out_sum",   ifc.out_sum,        32'hCAFEF00D);
            check("bp_chk_a",     chk_a,              32'h11111111);
        end
        ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
        @(negedge clk);
        ifc.out_ready = 1'b0;
        check("bp_release_ready", 32'(ifc.in_ready),  32'd1);
        check("bp_release_valid", 32'(ifc.out_valid), 32'd0);

        // Streaming at the minimum issue interval: two accepts in ten cycles
        @(negedge clk);
        ifc.in_valid = 1'b1; ifc.out_ready = 1'b1; ifc.in_a = 32'h0A0A0A0A;
        chk_used_sum = 32'h00FF00FF;
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ifc.out_valid) vcount++;
        end
        ifc.in_valid = 1'b0; ifc.out_ready = 1'b0;
        check("stream_valid_cycles", 32'(vcount),   32'd2);
        check("stream_punt_cnt",     32'(punt_cnt), 32'd4);
        repeat (8) @(negedge clk);

        // Saturate the fault and trunc counters, then clear during an EVAL with fault
        for (int i = 0; i < 16; i++)
            txn(32'h40000000 + 32'(i), 32'h1, 1'b1, 1'b1, 32'h00000100 + 32'(i), 32'h7000_0000, 1'b0, lat);
        check("sat_fault_cnt", 32'(fault_cnt), 32'hF);
        check("sat_trunc_cnt", 32'(trunc_cnt), 32'hF);
        txn(32'h40000000, 32'h40000000, 1'b1, 1'b1, 32'h00004800, 32'h4A000000, 1'b1, lat);
        check("clr_fault_cnt", 32'(fault_cnt), 32'd0);
        check("clr_trunc_cnt", 32'(trunc_cnt), 32'd0);
        check("clr_punt_cnt",  32'(punt_cnt),  32'd0);

        // Reset in SETTLE after a counted punt drops the pair and zeroes everything
        txn(32'h1, 32'h2, 1'b0, 1'b0, 32'h00000003, 32'h00000003, 1'b0, lat);
        @(negedge clk);
        ifc.in_valid = 1'b1; ifc.in_a = 32'h55555555; ifc.in_b = 32'h66666666;
        @(negedge clk);
        ifc.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_mid_in_ready",  32'(ifc.in_ready),  32'd1);
        check("rst_mid_out_valid", 32'(ifc.out_valid), 32'd0);
        check("rst_mid_punt_cnt",  32'(punt_cnt),      32'd0);
        check("rst_mid_chk_a",     chk_a,              32'h0);

        txn(32'h40000000, 32'h40000000, 1'b1, 1'b0, 32'h00004800, 32'h0, 1'b0, lat);
        check("post_rst_latency", 32'(lat),       32'd4);
        check("post_rst_out_sum", ifc.out_sum,    32'h48000000);
        check("post_rst_trunc",   32'(trunc_cnt), 32'd1);

        repeat (2) @(negedge clk);
        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
